// File: rtl/fifo_flag_ctrl.sv
// Pointer, count and flag tracker for the SDMAC longword FIFO.
// It also sequences the end-of-transfer flush of a partial longword.
module fifo_flag_ctrl #(
   parameter int DEPTH_LOG2 = 3
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  CLR,
   input  logic                  DMADIR,
   input  logic                  FLUSH_REQ,
   input  logic                  SCSI_INC,
   input  logic                  HOST_INC,
   output logic                  FIFOEMPTY,
   output logic                  FIFOFULL,
   output logic                  LASTWORD,
   output logic                  BOEQ3,
   output logic                  FLUSHFIFO,
   output logic                  FLUSHED,
   output logic [1:0]            BO,
   output logic [DEPTH_LOG2-1:0] WPTR,
   output logic [DEPTH_LOG2-1:0] RPTR,
   output logic [DEPTH_LOG2:0]   COUNT,
   output logic                  OVERFLOW,
   output logic                  UNDERFLOW
);

   typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_DONE} flush_st_e;

   localparam logic [DEPTH_LOG2:0] DEPTH_C = {1'b1, {DEPTH_LOG2{1'b0}}};

   logic                  dir_q, dir_d;
   logic [1:0]            bo_q, bo_d;
   logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  ovf_q, ovf_d, unf_q, unf_d;
   flush_st_e             st_q, st_d;

   logic full, empty, lastword, sc_wrap, fill, drain, fill_ok, drain_ok, part;

   assign full     = (count_q == DEPTH_C);
   assign empty    = (count_q == '0);
   assign lastword = (st_q == ST_FLUSH) && empty && (bo_q != 2'd0);
   assign sc_wrap  = SCSI_INC && (bo_q == 2'd3);
   assign fill     = dir_q ? sc_wrap : HOST_INC;
   assign drain    = dir_q ? HOST_INC : sc_wrap;
   // A full FIFO still accepts a fill when the other side drains this cycle,
   // and an empty one still drains when filled this cycle.
   assign fill_ok  = fill && (!full || drain);
   assign drain_ok = drain && (!empty || fill);
   // Host pulling the final partial longword out during a flush.
   assign part     = dir_q && lastword && HOST_INC;

   always_comb begin
      dir_d   = dir_q;
      bo_d    = bo_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      st_d    = st_q;
      if (CLR) begin
         dir_d   = DMADIR;
         bo_d    = 2'd0;
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
         ovf_d   = 1'b0;
         unf_d   = 1'b0;
         st_d    = ST_IDLE;
      end else begin
         if (part) begin
            bo_d   = 2'd0;
            wptr_d = wptr_q + DEPTH_LOG2'(1);
            rptr_d = rptr_q + DEPTH_LOG2'(1);
         end else begin
            if (SCSI_INC && (bo_q != 2'd3 || (dir_q ? fill_ok : drain_ok)))
               bo_d = bo_q + 2'd1;
            wptr_d = wptr_q + DEPTH_LOG2'(fill_ok);
            rptr_d = rptr_q + DEPTH_LOG2'(drain_ok);
            if (fill_ok && !drain_ok)
               count_d = count_q + 1'b1;
            else if (drain_ok && !fill_ok)
               count_d = count_q - 1'b1;
            ovf_d = ovf_q | (fill && !fill_ok);
            unf_d = unf_q | (drain && !drain_ok);
         end
         case (st_q)
            ST_IDLE:  if (FLUSH_REQ && dir_q) st_d = ST_FLUSH;
            ST_FLUSH: if (empty && bo_q == 2'd0) st_d = ST_DONE;
            default:  st_d = st_q;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         dir_q   <= 1'b0;
         bo_q    <= 2'd0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         st_q    <= ST_IDLE;
      end else begin
         dir_q   <= dir_d;
         bo_q    <= bo_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         st_q    <= st_d;
      end
   end

   assign FIFOEMPTY = empty;
   assign FIFOFULL  = full;
   assign LASTWORD  = lastword;
   assign BOEQ3     = (bo_q == 2'd3);
   assign FLUSHFIFO = (st_q == ST_FLUSH);
   assign FLUSHED   = (st_q == ST_DONE);
   assign BO        = bo_q;
   assign WPTR      = wptr_q;
   assign RPTR      = rptr_q;
   assign COUNT     = count_q;
   assign OVERFLOW  = ovf_q;
   assign UNDERFLOW = unf_q;

endmodule

// File: tb/tb_fifo_flag_ctrl.sv
// Directed bench for fifo_flag_ctrl with hand-computed expectations.
module tb_fifo_flag_ctrl;

   logic       CLK = 1'b0;
   logic       RST, CLR, DMADIR, FLUSH_REQ, SCSI_INC, HOST_INC;
   logic       FIFOEMPTY, FIFOFULL, LASTWORD, BOEQ3, FLUSHFIFO, FLUSHED;
   logic [1:0] BO;
   logic [2:0] WPTR, RPTR;
   logic [3:0] COUNT;
   logic       OVERFLOW, UNDERFLOW;

   int n_chk = 0;
   int n_pass = 0;

   fifo_flag_ctrl #(.DEPTH_LOG2(3)) dut (
      .CLK(CLK), .RST(RST), .CLR(CLR), .DMADIR(DMADIR), .FLUSH_REQ(FLUSH_REQ),
      .SCSI_INC(SCSI_INC), .HOST_INC(HOST_INC), .FIFOEMPTY(FIFOEMPTY),
      .FIFOFULL(FIFOFULL), .LASTWORD(LASTWORD), .BOEQ3(BOEQ3),
      .FLUSHFIFO(FLUSHFIFO), .FLUSHED(FLUSHED), .BO(BO), .WPTR(WPTR),
      .RPTR(RPTR), .COUNT(COUNT), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Apply one cycle of inputs, then sample 1ns after the edge.
   task automatic step(input logic s, input logic h, input logic f,
                       input logic c, input logic d);
      SCSI_INC = s; HOST_INC = h; FLUSH_REQ = f; CLR = c; DMADIR = d;
      @(posedge CLK); #1;
      SCSI_INC = 0; HOST_INC = 0; FLUSH_REQ = 0; CLR = 0;
   endtask

   task automatic scsi_n(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".empty"}, FIFOEMPTY, 1);
      chk({tag, ".full"}, FIFOFULL, 0);
      chk({tag, ".lastword"}, LASTWORD, 0);
      chk({tag, ".boeq3"}, BOEQ3, 0);
      chk({tag, ".flushfifo"}, FLUSHFIFO, 0);
      chk({tag, ".flushed"}, FLUSHED, 0);
      chk({tag, ".bo"}, BO, 0);
      chk({tag, ".wptr"}, WPTR, 0);
      chk({tag, ".rptr"}, RPTR, 0);
      chk({tag, ".count"}, COUNT, 0);
      chk({tag, ".ovf"}, OVERFLOW, 0);
      chk({tag, ".unf"}, UNDERFLOW, 0);
   endtask

   initial begin
      RST = 1; CLR = 0; DMADIR = 0; FLUSH_REQ = 0; SCSI_INC = 0; HOST_INC = 0;
      step(1, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk_reset_vals("rst");
      RST = 0;

      // SCSI-to-memory fill to full
      step(0, 0, 0, 1, 1);
      scsi_n(32);
      chk("fill.count", COUNT, 8);
      chk("fill.full", FIFOFULL, 1);
      chk("fill.empty", FIFOEMPTY, 0);
      chk("fill.wptr", WPTR, 0);
      chk("fill.bo", BO, 0);
      scsi_n(3);
      chk("fill35.bo", BO, 3);
      chk("fill35.boeq3", BOEQ3, 1);
      chk("fill35.ovf", OVERFLOW, 0);
      // Full + completing byte + host drain together
      step(1, 1, 0, 0, 0);
      chk("conc1.count", COUNT, 8);
      chk("conc1.wptr", WPTR, 1);
      chk("conc1.rptr", RPTR, 1);
      chk("conc1.bo", BO, 0);
      chk("conc1.ovf", OVERFLOW, 0);
      scsi_n(4);
      chk("ovf1.ovf", OVERFLOW, 1);
      chk("ovf1.count", COUNT, 8);
      chk("ovf1.bo", BO, 3);
      chk("ovf1.wptr", WPTR, 1);

      // Host drain on empty
      step(0, 0, 0, 1, 1);
      chk("clr.ovf", OVERFLOW, 0);
      step(0, 1, 0, 0, 0);
      chk("unf1.unf", UNDERFLOW, 1);
      chk("unf1.rptr", RPTR, 0);
      chk("unf1.count", COUNT, 0);

      // Flush with a partial longword
      step(0, 0, 0, 1, 1);
      scsi_n(10);
      chk("fl.count", COUNT, 2);
      chk("fl.bo", BO, 2);
      step(0, 0, 1, 0, 0);
      chk("fl.flushfifo", FLUSHFIFO, 1);
      chk("fl.empty", FIFOEMPTY, 0);
      chk("fl.lw0", LASTWORD, 0);
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      chk("fl.count0", COUNT, 0);
      chk("fl.rptr2", RPTR, 2);
      chk("fl.lw1", LASTWORD, 1);
      chk("fl.bo2", BO, 2);
      step(0, 1, 0, 0, 0);
      chk("fl.part.bo", BO, 0);
      chk("fl.part.lw", LASTWORD, 0);
      chk("fl.part.wptr", WPTR, 3);
      chk("fl.part.rptr", RPTR, 3);
      chk("fl.part.count", COUNT, 0);
      chk("fl.part.unf", UNDERFLOW, 0);
      chk("fl.part.flushfifo", FLUSHFIFO, 1);
      chk("fl.part.flushed", FLUSHED, 0);
      step(0, 0, 0, 0, 0);
      chk("fl.done.flushed", FLUSHED, 1);
      chk("fl.done.flushfifo", FLUSHFIFO, 0);
      step(0, 0, 1, 0, 0);
      chk("fl.done.req.flushed", FLUSHED, 1);
      chk("fl.done.req.flushfifo", FLUSHFIFO, 0);

      // Empty flush timing
      step(0, 0, 0, 1, 1);
      step(0, 0, 1, 0, 0);
      chk("efl.flushfifo", FLUSHFIFO, 1);
      chk("efl.flushed", FLUSHED, 0);
      step(0, 0, 0, 0, 0);
      chk("efl.flushed2", FLUSHED, 1);
      chk("efl.flushfifo2", FLUSHFIFO, 0);

      // Memory-to-SCSI
      step(0, 0, 0, 1, 0);
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      chk("m2s.count", COUNT, 2);
      chk("m2s.wptr", WPTR, 2);
      for (int i = 1; i <= 8; i++) begin
         step(1, 0, 0, 0, 0);
         chk($sformatf("m2s.boeq3.%0d", i), BOEQ3, (i == 3 || i == 7) ? 1 : 0);
      end
      chk("m2s.count0", COUNT, 0);
      chk("m2s.rptr", RPTR, 2);
      chk("m2s.bo0", BO, 0);
      step(1, 0, 0, 0, 0);
      chk("m2s.bo1", BO, 1);
      chk("m2s.unf0", UNDERFLOW, 0);
      scsi_n(2);
      chk("m2s.bo3", BO, 3);
      step(1, 0, 0, 0, 0);
      chk("m2s.unf", UNDERFLOW, 1);
      chk("m2s.unf.bo", BO, 3);
      chk("m2s.unf.rptr", RPTR, 2);
      step(0, 0, 1, 0, 0);
      chk("m2s.freq.flushfifo", FLUSHFIFO, 0);
      chk("m2s.freq.lw", LASTWORD, 0);
      step(0, 0, 0, 0, 0);
      chk("m2s.freq.flushed", FLUSHED, 0);
      for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0);
      chk("m2s.full", FIFOFULL, 1);
      chk("m2s.full.wptr", WPTR, 2);
      chk("m2s.ovf0", OVERFLOW, 0);
      step(0, 1, 0, 0, 0);
      chk("m2s.ovf", OVERFLOW, 1);
      chk("m2s.ovf.count", COUNT, 8);
      chk("m2s.ovf.wptr", WPTR, 2);
      step(1, 1, 0, 0, 0);
      chk("m2s.conc.count", COUNT, 8);
      chk("m2s.conc.wptr", WPTR, 3);
      chk("m2s.conc.rptr", RPTR, 3);
      chk("m2s.conc.bo", BO, 0);

      // Reset mid-flush
      step(0, 0, 0, 1, 1);
      scsi_n(12);
      chk("rfl.count", COUNT, 3);
      step(0, 0, 1, 0, 0);
      chk("rfl.flushfifo", FLUSHFIFO, 1);
      RST = 1;
      step(1, 1, 0, 0, 0);
      RST = 0;
      chk_reset_vals("rfl");

      // CLR swallows a concurrent byte
      step(0, 0, 0, 1, 1);
      scsi_n(2);
      chk("clrs.bo2", BO, 2);
      step(1, 0, 0, 1, 1);
      chk("clrs.bo", BO, 0);
      chk("clrs.wptr", WPTR, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fifo_flag_ctrl.md
# fifo_flag_ctrl

Pointer and flag tracker for the SDMAC longword FIFO; it sits directly upstream of the CPU state machine input decode. It produces the FIFOEMPTY, FIFOFULL, LASTWORD, BOEQ3 and FLUSHFIFO terms that the decode samples. It counts SCSI-side byte transfers and host-side longword transfers, maintains read/write pointers, and sequences the end-of-transfer flush of a partial longword.

## Interface
- DEPTH_LOG2, 3, log2 of FIFO depth in longwords (default 8 entries)
- CLK  in  1  system clock, all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- CLR  in  1  synchronous FIFO clear at DMA start; also latches DMADIR
- DMADIR  in  1  1 = SCSI-to-memory (bytes in, longwords out), 0 = memory-to-SCSI
- FLUSH_REQ  in  1  request flush of residual data (honoured only when latched direction = 1)
- SCSI_INC  in  1  one byte transferred on SCSI side this cycle
- HOST_INC  in  1  one longword transferred on host side this cycle
- FIFOEMPTY  out  1  COUNT == 0
- FIFOFULL  out  1  COUNT == 2^DEPTH_LOG2
- LASTWORD  out  1  flush pending with only a partial longword left
- BOEQ3  out  1  BO == 3
- FLUSHFIFO  out  1  flush in progress
- FLUSHED  out  1  flush completed; held until CLR/RST
- BO  out  2  byte offset within current SCSI-side longword (= valid bytes of partial longword)
- WPTR  out  DEPTH_LOG2  write pointer
- RPTR  out  DEPTH_LOG2  read pointer
- COUNT  out  DEPTH_LOG2+1  complete longwords held
- OVERFLOW  out  1  sticky: increment ignored because FIFO full
- UNDERFLOW  out  1  sticky: increment ignored because FIFO empty

## Operation
- Priority per cycle: RST > CLR > everything else. CLR zeroes pointers, COUNT, BO, flags and the flush state, and loads DIR ← DMADIR. DIR is the only direction used internally.
- DIR = 1:
  - SCSI_INC increments BO. On BO 3→0, WPTR advances and COUNT increments.
  - HOST_INC advances RPTR and decrements COUNT.
- DIR = 0:
  - HOST_INC advances WPTR and increments COUNT.
  - SCSI_INC increments BO. On BO 3→0, RPTR advances and COUNT decrements.
- Both SCSI_INC and HOST_INC in the same cycle: both applied, and COUNT takes the net change. A full FIFO may accept a completing byte/longword if the other side drains in the same cycle. The same applies to an empty FIFO with a concurrent fill.
- Overflow: any increment that would take COUNT above depth is ignored in full and sets OVERFLOW. This covers DIR=1 SCSI_INC with BO=3, and DIR=0 HOST_INC.
- Underflow: any increment that would take COUNT below 0 is ignored in full and sets UNDERFLOW. This covers DIR=1 HOST_INC, and DIR=0 SCSI_INC with BO=3. The exception is the partial consume below.
- Pointers wrap modulo 2^DEPTH_LOG2.
- Flush FSM states: IDLE, FLUSH, DONE.
  - IDLE→FLUSH on FLUSH_REQ when DIR = 1. Otherwise FLUSH_REQ is ignored.
  - In FLUSH: FLUSHFIFO = 1, and LASTWORD = (COUNT == 0) & (BO != 0).
  - In FLUSH with LASTWORD = 1, HOST_INC is a partial consume: BO ← 0, WPTR and RPTR both advance, COUNT stays 0, no UNDERFLOW.
  - FLUSH→DONE when COUNT == 0 and BO == 0 (evaluated on registered state).
  - DONE: FLUSHFIFO = 0, FLUSHED = 1, LASTWORD = 0. DONE→IDLE only on CLR/RST.
  - FLUSH_REQ in FLUSH or DONE has no effect. SCSI_INC during FLUSH is still accepted normally.

## Timing
- All inputs sampled on the rising CLK edge. Outputs are decodes of registered state, so they are valid in the cycle immediately after the causing edge. There is no further latency.
- Reset/CLR values: FIFOEMPTY = 1. FIFOFULL = 0, LASTWORD = 0, BOEQ3 = 0, FLUSHFIFO = 0, FLUSHED = 0. BO = 0, WPTR = 0, RPTR = 0, COUNT = 0. OVERFLOW = 0, UNDERFLOW = 0. FSM = IDLE.
- Reset/CLR mid-transfer or mid-flush discards all content with no residual effects. Any increments in the same cycle as CLR are ignored.
- FLUSH→DONE takes one cycle after the condition holds. With an empty FIFO and BO=0, FLUSH_REQ at edge n gives FLUSHFIFO high for cycle n+1 and FLUSHED high from n+2.
- FIFOFULL/FIFOEMPTY never both high.

## Test plan
- RST, CLR with DMADIR=1, then 32 SCSI_INC pulses → COUNT=8, FIFOFULL=1, WPTR=0 (wrapped), BO=0. A 33rd–36th SCSI_INC: BO goes to 3 and the 36th sets OVERFLOW with COUNT still 8.
- DIR=1, FIFO full, SCSI_INC (BO=3) and HOST_INC in the same cycle → COUNT stays 8, WPTR and RPTR each +1, BO=0, no OVERFLOW.
- DIR=1, 10 SCSI_INC then FLUSH_REQ → FLUSHFIFO=1, FIFOEMPTY=0. Two HOST_INC → COUNT=0 and LASTWORD=1 with BO=2. Third HOST_INC → BO=0, LASTWORD=0. Next cycle FLUSHED=1, FLUSHFIFO=0.
- DIR=0: 2 HOST_INC, then 8 SCSI_INC → COUNT=0, RPTR=2, BOEQ3 high after bytes 3 and 7. A 9th SCSI_INC with BO=0 is accepted (BO=1). SCSI_INC with BO=3 and COUNT=0 sets UNDERFLOW.
- FLUSH_REQ with DIR=0 → FSM stays IDLE, FLUSHFIFO=0.
- RST asserted in FLUSH with COUNT=3 → next cycle all outputs at reset values. Also check CLR with simultaneous SCSI_INC → BO=0.
